// File: rtl/adjust_pkg.sv
// Shared definitions for the clock-adjust control stage: state codes
// (also the field_sel display value) and default timing constants.
package adjust_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SEC   = 3'd1,
    ST_MIN   = 3'd2,
    ST_HOUR  = 3'd3,
    ST_DAY   = 3'd4,
    ST_MONTH = 3'd5,
    ST_YEAR  = 3'd6
  } state_e;

  localparam int unsigned N_FIELDS         = 6;
  localparam int unsigned TIMEOUT_S_DEF    = 30;
  localparam int unsigned REPEAT_DELAY_DEF = 2;

  function automatic state_e next_state(input state_e s);
    return (s == ST_YEAR) ? ST_RUN : state_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/adjust_ctrl_key_repeat.sv
// Per-key edge detect and held-key auto-repeat; pulse is combinational and
// registered by the instantiating block.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic allow,
  input  logic clr,
  output logic pulse
);

  logic       prev_q;
  logic       rdy_q;
  logic       armed_q, armed_d;
  logic [3:0] hold_q, hold_d;
  logic       press;

  // rdy_q masks a key that was already down when reset released
  assign press = key & ~prev_q & rdy_q;

  always_comb begin
    hold_d  = hold_q;
    armed_d = armed_q;
    pulse   = 1'b0;
    if (clr || !key) begin
      hold_d  = '0;
      armed_d = 1'b0;
    end else if (!allow) begin
      armed_d = 1'b0;
    end else if (press) begin
      pulse   = 1'b1;
      armed_d = 1'b1;
      hold_d  = '0;
    end else if (armed_q) begin
      if (hold_q == 4'(REPEAT_DELAY)) pulse = 1'b1;
      else                            hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      prev_q  <= key;
      rdy_q   <= rdy_q | ~key;
      armed_q <= armed_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/adjust_ctrl.sv
// Key-to-control front end for the clock counter chain: field select FSM,
// inactivity timeout, up/down auto-repeat and registered per-field outputs.
module adjust_ctrl
  import adjust_pkg::*;
#(
  parameter int unsigned TIMEOUT_S    = TIMEOUT_S_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  output logic       en_1,
  output logic       adjust_sec,
  output logic       adjust_min,
  output logic       adjust_hour,
  output logic       adjust_day,
  output logic       adjust_month,
  output logic       adjust_year,
  output logic       up_sec,
  output logic       up_min,
  output logic       up_hour,
  output logic       up_day,
  output logic       up_month,
  output logic       up_year,
  output logic       down_sec,
  output logic       down_min,
  output logic       down_hour,
  output logic       down_day,
  output logic       down_month,
  output logic       down_year,
  output logic [2:0] field_sel
);

  state_e                state_q, state_d;
  logic [7:0]            idle_q, idle_d;
  logic                  mode_prev_q, mode_rdy_q, mode_press;
  logic                  in_set, chg, allow, clr;
  logic                  up_pulse, dn_pulse;
  logic                  en_q;
  logic [N_FIELDS-1:0]   adj_q, adj_d, up_q, up_d, dn_q, dn_d;

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY)) u_up (
    .clk(clk_1Hz), .rst(rst), .key(key_up), .allow(allow), .clr(clr), .pulse(up_pulse)
  );

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY)) u_down (
    .clk(clk_1Hz), .rst(rst), .key(key_down), .allow(allow), .clr(clr), .pulse(dn_pulse)
  );

  always_comb begin
    mode_press = key_mode & ~mode_prev_q & mode_rdy_q;
    in_set     = (state_q != ST_RUN);
    state_d    = state_q;
    idle_d     = idle_q;
    if (mode_press) begin
      state_d = next_state(state_q);
    end else if (in_set) begin
      if (key_up | key_down)                   idle_d  = '0;
      else if (idle_q == 8'(TIMEOUT_S - 1))    state_d = ST_RUN;
      else                                     idle_d  = idle_q + 8'd1;
    end
    chg = (state_d != state_q);
    if (chg || !in_set) idle_d = '0;
    allow = in_set & ~(key_up & key_down);
    // a state change also cancels repeat so the new field needs a fresh press
    clr   = ~in_set | chg;
  end

  always_comb begin
    adj_d = '0;
    up_d  = '0;
    dn_d  = '0;
    for (int unsigned i = 0; i < N_FIELDS; i++) begin
      adj_d[i] = (state_d == state_e'(3'(i + 1)));
      up_d[i]  = up_pulse & (state_q == state_e'(3'(i + 1)));
      dn_d[i]  = dn_pulse & (state_q == state_e'(3'(i + 1)));
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      idle_q      <= '0;
      mode_prev_q <= 1'b0;
      mode_rdy_q  <= 1'b0;
      en_q        <= 1'b1;
      adj_q       <= '0;
      up_q        <= '0;
      dn_q        <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      mode_prev_q <= key_mode;
      mode_rdy_q  <= mode_rdy_q | ~key_mode;
      en_q        <= (state_d == ST_RUN);
      adj_q       <= adj_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
    end
  end

  assign en_1      = en_q;
  assign field_sel = state_q;
  assign {adjust_year, adjust_month, adjust_day, adjust_hour, adjust_min, adjust_sec} = adj_q;
  assign {up_year, up_month, up_day, up_hour, up_min, up_sec}                         = up_q;
  assign {down_year, down_month, down_day, down_hour, down_min, down_sec}             = dn_q;

endmodule
